key_entry_ctrl: RTL and testbench

Sequencer between the 4x4 keypad scanner and the calculator datapath/transmit path. It synchronises the scanner's `keyPressed`/`num` outputs into the system clock domain and turns each new press into one key event. From those events it assembles a two-operand BCD expression (operand A, operator, operand B), then presents it downstream with a valid/ready handshake. It also drives the operand currently being edited to the display path and flags entry errors.

---
 rtl/key_entry_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_key_entry_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl
// Sits between the keypad scanner and the calculator datapath. The scanner's
// keyPressed/num outputs are brought into the clk domain and each press
// becomes one key event. Events build an "A op B" BCD expression, which is
// then offered downstream on a valid/ready handshake. Also drives the operand
// being edited to the display and flags entry overflow.
module key_entry_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  keyPressed,
    input  logic [3:0]            num,
    output logic                  expr_valid,
    input  logic                  expr_ready,
    output logic [4*DIGITS-1:0]   op_a,
    output logic [4*DIGITS-1:0]   op_b,
    output logic [1:0]            op,
    output logic [4*DIGITS-1:0]   disp,
    output logic                  entry_err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        ST_A_ENT = 2'd0,
        ST_B_ENT = 2'd1,
        ST_SEND  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and key event registers
    // ------------------------------------------------------------------
    logic         r_k1;
    logic         r_k2;
    logic         r_k3;
    logic [3:0]   r_n1;
    logic [3:0]   r_n2;
    logic         r_key_vld;
    logic [3:0]   r_key_code;
    logic         w_key_edge;

    // ------------------------------------------------------------------
    // Expression state
    // ------------------------------------------------------------------
    state_t       r_state;
    state_t       w_state_next;
    logic [W-1:0] r_op_a;
    logic [W-1:0] w_op_a_next;
    logic [W-1:0] r_op_b;
    logic [W-1:0] w_op_b_next;
    logic [CW-1:0] r_cnt_a;
    logic [CW-1:0] w_cnt_a_next;
    logic [CW-1:0] r_cnt_b;
    logic [CW-1:0] w_cnt_b_next;
    logic [1:0]   r_op;
    logic [1:0]   w_op_next;
    logic         r_expr_valid;

    // Key classification
    logic         w_is_digit;
    logic         w_is_oper;
    logic         w_is_equal;
    logic         w_is_clear;
    logic [1:0]   w_oper_code;
    logic         w_xfer;
    logic         w_a_full;
    logic         w_b_full;
    logic [W-1:0] w_err_fill;

    // Three-flop synchroniser on keyPressed (third flop feeds edge detect),
    // two-flop synchroniser on the key code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_k1 <= 1'b0;
            r_k2 <= 1'b0;
            r_k3 <= 1'b0;
            r_n1 <= 4'd0;
            r_n2 <= 4'd0;
        end else begin
            r_k1 <= keyPressed;
            r_k2 <= r_k1;
            r_k3 <= r_k2;
            r_n1 <= num;
            r_n2 <= r_n1;
        end
    end

    // A rising edge of the synchronised key flag is one key event; a code
    // change while the key stays high does not produce another edge.
    assign w_key_edge = r_k2 & ~r_k3;

    // Register the one-cycle key event pulse together with its code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key_vld  <= 1'b0;
            r_key_code <= 4'd0;
        end else begin
            r_key_vld <= w_key_edge;
            if (w_key_edge) begin
                r_key_code <= r_n2;
            end
        end
    end

    // Key code decode: 0-9 digits, a-d operators, e equals, f clear.
    assign w_is_digit  = (r_key_code <= 4'd9);
    assign w_is_oper   = (r_key_code >= 4'ha) && (r_key_code <= 4'hd);
    assign w_is_equal  = (r_key_code == 4'he);
    assign w_is_clear  = (r_key_code == 4'hf);
    assign w_oper_code = r_key_code[1:0] - 2'd2;   // a->0, b->1, c->2, d->3

    assign w_a_full = (r_cnt_a == CW'(DIGITS));
    assign w_b_full = (r_cnt_b == CW'(DIGITS));

    // Valid is only ever high in SEND, so valid & ready is the transfer.
    assign w_xfer = r_expr_valid & expr_ready;

    // Next-state and next-datapath decode for the entry sequencer.
    always_comb begin
        w_state_next = r_state;
        w_op_a_next  = r_op_a;
        w_op_b_next  = r_op_b;
        w_cnt_a_next = r_cnt_a;
        w_cnt_b_next = r_cnt_b;
        w_op_next    = r_op;

        // Completed transfer returns to an empty expression.
        if (w_xfer) begin
            w_state_next = ST_A_ENT;
            w_op_a_next  = '0;
            w_op_b_next  = '0;
            w_cnt_a_next = '0;
            w_cnt_b_next = '0;
            w_op_next    = 2'd0;
        end

        if (r_key_vld) begin
            if (w_is_clear) begin
                // Clear wins everywhere; coinciding with a transfer gives the
                // same all-zero A_ENT result.
                w_state_next = ST_A_ENT;
                w_op_a_next  = '0;
                w_op_b_next  = '0;
                w_cnt_a_next = '0;
                w_cnt_b_next = '0;
                w_op_next    = 2'd0;
            end else begin
                case (r_state)
                    ST_A_ENT: begin
                        if (w_is_digit) begin
                            if (w_a_full) begin
                                w_state_next = ST_ERR;
                            end else begin
                                w_op_a_next  = {r_op_a[W-5:0], r_key_code};
                                w_cnt_a_next = r_cnt_a + CW'(1);
                            end
                        end else if (w_is_oper && (r_cnt_a != '0)) begin
                            w_op_next    = w_oper_code;
                            w_state_next = ST_B_ENT;
                        end
                    end
                    ST_B_ENT: begin
                        if (w_is_digit) begin
                            if (w_b_full) begin
                                w_state_next = ST_ERR;
                            end else begin
                                w_op_b_next  = {r_op_b[W-5:0], r_key_code};
                                w_cnt_b_next = r_cnt_b + CW'(1);
                            end
                        end else if (w_is_oper && (r_cnt_b == '0)) begin
                            // Operator typed again before B digits: replace it.
                            w_op_next = w_oper_code;
                        end else if (w_is_equal && (r_cnt_b != '0)) begin
                            w_state_next = ST_SEND;
                        end
                    end
                    // SEND holds the expression stable; ERR waits for clear.
                    default: begin
                    end
                endcase
            end
        end
    end

    // State, operand and handshake registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_A_ENT;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_cnt_a      <= '0;
            r_cnt_b      <= '0;
            r_op         <= 2'd0;
            r_expr_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_op_a       <= w_op_a_next;
            r_op_b       <= w_op_b_next;
            r_cnt_a      <= w_cnt_a_next;
            r_cnt_b      <= w_cnt_b_next;
            r_op         <= w_op_next;
            r_expr_valid <= (w_state_next == ST_SEND);
        end
    end

    // Error display pattern: every nibble 4'hF.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_err_fill
            assign w_err_fill[4*gi +: 4] = 4'hF;
        end
    endgenerate

    // Display selects the operand being edited, decoded straight from registers.
    always_comb begin
        disp = r_op_a;
        case (r_state)
            ST_A_ENT: disp = r_op_a;
            ST_B_ENT: disp = (r_cnt_b != '0) ? r_op_b : r_op_a;
            ST_SEND:  disp = r_op_b;
            ST_ERR:   disp = w_err_fill;
            default:  disp = r_op_a;
        endcase
    end

    assign entry_err  = (r_state == ST_ERR);
    assign expr_valid = r_expr_valid;
    assign op_a       = r_op_a;
    assign op_b       = r_op_b;
    assign op         = r_op;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Testbench for key_entry_ctrl: scenario tasks drive keypad presses; expected
// expressions are queued when stimulus is driven and compared when the DUT
// completes a valid/ready transfer.
module tb_key_entry_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         keyPressed = 1'b0;
    logic [3:0]   num = 4'd0;
    logic         expr_ready = 1'b0;
    logic         expr_valid;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [1:0]   op;
    logic [W-1:0] disp;
    logic         entry_err;

    typedef struct packed {
        logic [W-1:0] a;
        logic [1:0]   o;
        logic [W-1:0] b;
    } expr_t;

    expr_t exp_q[$];
    int    vld_cyc_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    n_xfer = 0;
    int    vrun = 0;
    int    last_run = 0;

    key_entry_ctrl #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .keyPressed (keyPressed),
        .num        (num),
        .expr_valid (expr_valid),
        .expr_ready (expr_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op         (op),
        .disp       (disp),
        .entry_err  (entry_err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Scoreboard side: watch key events and transfers on the falling edge.
    initial begin
        expr_t e;
        forever begin
            @(negedge clk);
            if (dut.r_key_vld) vld_cyc_q.push_back(cyc);
            if (expr_valid) vrun++; else vrun = 0;
            if (expr_valid && expr_ready) begin
                n_xfer++;
                last_run = vrun;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL xfer_unexpected got a=%h op=%0d b=%h required none", op_a, op, op_b);
                end else begin
                    e = exp_q.pop_front();
                    if ({op_a, op, op_b} !== e) begin
                        errors++;
                        $display("FAIL xfer_expr got a=%h op=%0d b=%h required a=%h op=%0d b=%h",
                                 op_a, op, op_b, e.a, e.o, e.b);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [3:0] code);
        @(posedge clk);
        #2;
        num = code;
        keyPressed = 1'b1;
        tick(6);
        keyPressed = 1'b0;
        tick(6);
    endtask

    task automatic keys(input string s);
        for (int i = 0; i < s.len(); i++) begin
            int c;
            c = int'(s[i]);
            if (c >= int'("a")) press(4'(c - int'("a") + 10));
            else                press(4'(c - int'("0")));
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        checks++;
        if ({expr_valid, entry_err, op, op_a, op_b, disp} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b e=%b op=%0d a=%h b=%h d=%h required all 0",
                     expr_valid, entry_err, op, op_a, op_b, disp);
        end
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_add();
        int n0;
        expr_ready = 1'b1;
        keys("12a");
        checks++;
        if (disp !== 16'h0012) begin
            errors++; $display("FAIL add_disp_opA got %h required 0012", disp);
        end
        keys("34");
        checks++;
        if (disp !== 16'h0034) begin
            errors++; $display("FAIL add_disp_opB got %h required 0034", disp);
        end
        n0 = n_xfer;
        exp_q.push_back('{a: 16'h0012, o: 2'd0, b: 16'h0034});
        keys("e");
        checks++;
        if (n_xfer !== n0 + 1) begin
            errors++; $display("FAIL add_xfer_count got %0d required %0d", n_xfer, n0 + 1);
        end
        checks++;
        if (last_run !== 1) begin
            errors++; $display("FAIL add_valid_cycles got %0d required 1", last_run);
        end
        checks++;
        if ({expr_valid, disp} !== '0) begin
            errors++; $display("FAIL add_after got v=%b disp=%h required v=0 disp=0000", expr_valid, disp);
        end
    endtask

    task automatic test_div_replace();
        int    n0;
        int    waited;
        expr_t e;
        expr_ready = 1'b0;
        keys("9cd5");
        checks++;
        if (disp !== 16'h0005) begin
            errors++; $display("FAIL div_disp got %h required 0005", disp);
        end
        e = '{a: 16'h0009, o: 2'd3, b: 16'h0005};
        exp_q.push_back(e);
        n0 = n_xfer;
        @(posedge clk);
        #2;
        num = 4'he;
        keyPressed = 1'b1;
        waited = 0;
        while (!expr_valid && waited < 20) begin
            tick(1);
            waited++;
        end
        checks++;
        if (waited !== 4) begin
            errors++; $display("FAIL div_event_latency got %0d edges required 4", waited);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({expr_valid, op_a, op, op_b} !== {1'b1, e}) begin
                errors++;
                $display("FAIL div_hold%0d got v=%b a=%h op=%0d b=%h required v=1 a=%h op=%0d b=%h",
                         i, expr_valid, op_a, op, op_b, e.a, e.o, e.b);
            end
            tick(1);
        end
        keyPressed = 1'b0;
        expr_ready = 1'b1;
        tick(1);
        checks++;
        if (n_xfer !== n0 + 1 || last_run !== 11) begin
            errors++; $display("FAIL div_xfer got n=%0d run=%0d required n=%0d run=11", n_xfer, last_run, n0 + 1);
        end
        checks++;
        if (expr_valid !== 1'b0) begin
            errors++; $display("FAIL div_valid_drop got %b required 0", expr_valid);
        end
        tick(6);
    endtask

    task automatic test_overflow();
        keys("11111");
        checks++;
        if (entry_err !== 1'b1 || disp !== 16'hFFFF) begin
            errors++; $display("FAIL ovf_err got err=%b disp=%h required err=1 disp=ffff", entry_err, disp);
        end
        keys("2e");
        checks++;
        if (entry_err !== 1'b1 || op_a !== 16'h1111 || expr_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_drop got err=%b a=%h v=%b required err=1 a=1111 v=0", entry_err, op_a, expr_valid);
        end
        keys("f");
        checks++;
        if (entry_err !== 1'b0 || disp !== 16'h0000 || op_a !== 16'h0000) begin
            errors++; $display("FAIL ovf_clear got err=%b disp=%h a=%h required err=0 disp=0000 a=0000", entry_err, disp, op_a);
        end
    endtask

    task automatic test_hold();
        int c0;
        int c1;
        vld_cyc_q.delete();
        @(posedge clk);
        #2;
        c0 = cyc;
        num = 4'd7;
        keyPressed = 1'b1;
        tick(100);
        num = 4'd9;            // code change without release: no new event
        tick(100);
        keyPressed = 1'b0;
        tick(6);
        @(posedge clk);
        #2;
        c1 = cyc;
        num = 4'd7;
        keyPressed = 1'b1;
        tick(6);
        keyPressed = 1'b0;
        tick(6);
        checks++;
        if (vld_cyc_q.size() !== 2) begin
            errors++; $display("FAIL hold_pulse_count got %0d required 2", vld_cyc_q.size());
        end else begin
            checks++;
            if (vld_cyc_q[0] !== c0 + 3 || vld_cyc_q[1] !== c1 + 3) begin
                errors++; $display("FAIL hold_pulse_time got %0d,%0d required %0d,%0d",
                                   vld_cyc_q[0], vld_cyc_q[1], c0 + 3, c1 + 3);
            end
        end
        checks++;
        if (op_a !== 16'h0077) begin
            errors++; $display("FAIL hold_opA got %h required 0077", op_a);
        end
        keys("f");
    endtask

    task automatic test_send_drop();
        int n0;
        expr_ready = 1'b0;
        n0 = n_xfer;
        keys("4b6e");
        checks++;
        if (expr_valid !== 1'b1 || op !== 2'd1) begin
            errors++; $display("FAIL send_enter got v=%b op=%0d required v=1 op=1", expr_valid, op);
        end
        keys("8");
        checks++;
        if (op_b !== 16'h0006 || expr_valid !== 1'b1 || disp !== 16'h0006) begin
            errors++; $display("FAIL send_drop8 got b=%h v=%b disp=%h required b=0006 v=1 disp=0006", op_b, expr_valid, disp);
        end
        keys("f");
        checks++;
        if (expr_valid !== 1'b0 || n_xfer !== n0 || {op_a, op_b, op, disp} !== '0) begin
            errors++; $display("FAIL send_clear got v=%b n=%0d a=%h b=%h op=%0d disp=%h required v=0 n=%0d zeros",
                               expr_valid, n_xfer, op_a, op_b, op, disp, n0);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        expr_ready = 1'b1;
        n0 = n_xfer;
        exp_q.push_back('{a: 16'h0005, o: 2'd3, b: 16'h0000});
        keys("5d0ae");         // divide by zero passes; 'a' after B digit ignored
        exp_q.push_back('{a: 16'h0987, o: 2'd2, b: 16'h0012});
        keys("ae987c12e");     // leading operator/equals ignored with empty A
        checks++;
        if (n_xfer !== n0 + 2) begin
            errors++; $display("FAIL b2b_count got %0d required %0d", n_xfer, n0 + 2);
        end
        expr_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        keys("123");
        checks++;
        if (op_a !== 16'h0123) begin
            errors++; $display("FAIL ares_pre got %h required 0123", op_a);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({expr_valid, entry_err, op, op_a, op_b, disp} !== '0) begin
            errors++; $display("FAIL ares_async got a=%h b=%h disp=%h op=%0d required all 0", op_a, op_b, disp, op);
        end
        tick(2);
        reset = 1'b1;
        keys("2");
        checks++;
        if (op_a !== 16'h0002) begin
            errors++; $display("FAIL ares_after got %h required 0002", op_a);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_div_replace();
        test_overflow();
        test_hold();
        test_send_drop();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL scoreboard_left got %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
